// File: rtl/alu_bist_pkg.sv
// Shared types, opcodes and vector ROM for the ALU self-test sequencer.
// Optional feature macro: ALU_BIST_STOP_ON_FAIL_EN (see alu_bist_ctrl).
package alu_bist_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int         NUM_VEC  = 11;
  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);
  localparam logic [3:0] NO_FAIL  = 4'hF;

  localparam logic [31:0] OPA = 32'd123;
  localparam logic [31:0] OPB = 32'd456;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } vec_t;

  // Fixed test vector ROM, packed as {A, B, op}
  function automatic vec_t bist_vec(input logic [3:0] idx);
    vec_t v;
    v = '{a: OPA, b: OPB, op: ALU_AND};
    case (idx)
      4'd0:  v = '{a: OPA, b: OPB, op: ALU_AND};
      4'd1:  v = '{a: OPA, b: OPB, op: ALU_OR};
      4'd2:  v = '{a: OPA, b: OPB, op: ALU_ADD};
      4'd3:  v = '{a: OPA, b: OPB, op: ALU_XOR};
      4'd4:  v = '{a: OPA, b: OPB, op: ALU_NOR};
      4'd5:  v = '{a: OPA, b: OPB, op: ALU_SUB};
      4'd6:  v = '{a: OPA, b: OPB, op: ALU_SLT};
      4'd7:  v = '{a: OPA, b: OPA, op: ALU_SUB};
      4'd8:  v = '{a: OPA, b: OPA, op: ALU_SLT};
      4'd9:  v = '{a: 32'hFFFF_FFFF, b: 32'd1, op: ALU_ADD};
      4'd10: v = '{a: 32'h8000_0000, b: 32'd1, op: ALU_SLT};
      default: v = '{a: OPA, b: OPB, op: ALU_AND};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_bist_golden.sv
// Combinational reference ALU used to produce the expected result
// and zero flag for the vector currently driven onto the ALU.
module alu_golden
  import alu_bist_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] exp_c,
  output logic        exp_zero
);

  // Reference operation select; opcode 101 is unused and yields 0
  always_comb begin
    exp_c = '0;
    case (op)
      ALU_AND: exp_c = a & b;
      ALU_OR:  exp_c = a | b;
      ALU_ADD: exp_c = a + b;
      ALU_XOR: exp_c = a ^ b;
      ALU_NOR: exp_c = ~(a | b);
      ALU_SUB: exp_c = a - b;
      ALU_SLT: exp_c = {31'd0, $signed(a) < $signed(b)};
      default: exp_c = '0;
    endcase
  end

  assign exp_zero = (exp_c == 32'd0);

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU built-in self-test sequencer: drive ROM vectors, settle, check.
// Define ALU_BIST_STOP_ON_FAIL_EN to halt on the first failing vector.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [3:0]  fail_idx
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [2:0]  settle_cnt;
  logic [31:0] exp_c;
  logic        exp_zero;
  logic        mismatch;
  logic        stop_now;
  logic [3:0]  err_inc;
  vec_t        cur_vec;

  alu_golden u_golden (
    .a        (alu_a),
    .b        (alu_b),
    .op       (alu_op),
    .exp_c    (exp_c),
    .exp_zero (exp_zero)
  );

  assign cur_vec  = bist_vec(idx);
  assign mismatch = (alu_c != exp_c) || (alu_zero != exp_zero);
  assign err_inc  = (err_count == 4'hF) ? err_count : err_count + 4'd1;

  // Decide whether the current CHECK ends the run
  always_comb begin
    stop_now = (idx == LAST_IDX);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    stop_now = stop_now || mismatch;
`else
    stop_now = stop_now;
`endif
  end

  // Sequencer FSM with registered ALU drive and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_idx   <= NO_FAIL;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            idx       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_idx  <= NO_FAIL;
          end
        end
        S_DRIVE: begin
          alu_a      <= cur_vec.a;
          alu_b      <= cur_vec.b;
          alu_op     <= cur_vec.op;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (fail_idx == NO_FAIL) begin
              fail_idx <= idx;
            end
          end
          if (stop_now) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == 4'd0);
          end else begin
            idx   <= idx + 4'd1;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Randomized self-checking bench for alu_bist_ctrl with a faultable ALU.
// The expected verdict of every run comes from a vector-level model.
module tb_alu_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        busy, done, pass;
  logic [3:0]  err_count, fail_idx;

  int checks = 0;
  int errors = 0;

  int          mode = 0;
  logic [7:0]  fmask = '0;
  logic [31:0] flip = '0;

  logic [31:0] va [11];
  logic [31:0] vb [11];
  logic [2:0]  vop[11];

  alu_bist_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .alu_zero  (alu_zero),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_idx  (fail_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] good_c(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd6: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      3'd7: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] bad_c(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
    input int m, input logic [7:0] msk, input logic [31:0] fl);
    logic [31:0] c;
    c = good_c(a, b, op);
    if (m == 1 && op == 3'd1) c = a & b;
    if (m == 3 && op == 3'd2) c = c + 32'd1;
    if (m == 4 && msk[op]) c = c ^ fl;
    return c;
  endfunction

  // Faultable ALU seen by the sequencer
  always_comb begin
    alu_c    = bad_c(alu_a, alu_b, alu_op, mode, fmask, flip);
    alu_zero = (mode == 2) ? 1'b0 : (alu_c == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_a"}, alu_a, 0);
    check({tag, "_op"}, 32'(alu_op), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_err"}, 32'(err_count), 0);
    check({tag, "_fidx"}, 32'(fail_idx), 32'hF);
  endtask

  // One full run; expectations derived vector by vector from the rules
  task automatic run(input string tag, input bit poke_start);
    int nfail, first, last, done_edge;
    logic [31:0] gc, bc;
    logic gz, bz;
    bit stop_fail;
    stop_fail = 0;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    stop_fail = 1;
`endif
    nfail = 0;
    first = 15;
    last  = 10;
    for (int i = 0; i < 11; i++) begin
      gc = good_c(va[i], vb[i], vop[i]);
      gz = (gc == 0);
      bc = bad_c(va[i], vb[i], vop[i], mode, fmask, flip);
      bz = (mode == 2) ? 1'b0 : (bc == 0);
      if (gc != bc || gz != bz) begin
        nfail++;
        if (first == 15) first = i;
        if (stop_fail) begin
          last = i;
          break;
        end
      end
    end
    done_edge = 3 * (last + 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 1);
    for (int k = 1; k <= done_edge; k++) begin
      @(posedge clk);
      #1;
      if (poke_start && k == 5) start = 1'b1;
      if (poke_start && k == 6) start = 1'b0;
      if (k % 3 == 1) begin
        check({tag, "_va"}, alu_a, va[k / 3]);
        check({tag, "_vb"}, alu_b, vb[k / 3]);
        check({tag, "_vop"}, 32'(alu_op), 32'(vop[k / 3]));
      end
      if (k == done_edge - 1) check({tag, "_early"}, 32'(done), 0);
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pass"}, 32'(pass), 32'(nfail == 0));
    check({tag, "_err"}, 32'(err_count), 32'(nfail > 15 ? 15 : nfail));
    check({tag, "_fidx"}, 32'(fail_idx), 32'(first));
    check({tag, "_hold"}, 32'(alu_op), 32'(vop[last]));
    repeat (2) @(posedge clk);
    #1 check({tag, "_keep"}, 32'(done), 1);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) begin
      va[i] = 32'd123;
      vb[i] = 32'd456;
    end
    vop[0] = 3'd0; vop[1] = 3'd1; vop[2] = 3'd2; vop[3] = 3'd3;
    vop[4] = 3'd4; vop[5] = 3'd6; vop[6] = 3'd7;
    va[7] = 32'd123; vb[7] = 32'd123; vop[7] = 3'd6;
    va[8] = 32'd123; vb[8] = 32'd123; vop[8] = 3'd7;
    va[9] = 32'hFFFF_FFFF; vb[9] = 32'd1; vop[9] = 3'd2;
    va[10] = 32'h8000_0000; vb[10] = 32'd1; vop[10] = 3'd7;

    check("g_and", good_c(va[0], vb[0], vop[0]), 32'd72);
    check("g_sub", good_c(va[5], vb[5], vop[5]), 32'hFFFF_FEB3);
    check("g_wrap", good_c(va[9], vb[9], vop[9]), 32'd0);
    check("g_slt", good_c(va[10], vb[10], vop[10]), 32'd1);

    rst = 1'b1;
    start = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    mode = 0; run("clean", 1'b0);
    mode = 1; run("or_and", 1'b0);
    mode = 2; run("zstuck", 1'b0);
    mode = 3; run("addflt", 1'b0);
    mode = 0; run("poke", 1'b1);

    // Abort mid-run with reset, then rerun cleanly
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 1'b0);

    for (int r = 0; r < 6; r++) begin
      mode  = 4;
      fmask = 8'($urandom_range(0, 255));
      flip  = $urandom | 32'd1;
      if (r == 0) fmask = 8'h00;
      run("rand", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist_ctrl.md
# alu_bist_ctrl

Synthesizable self-test sequencer for the single-cycle CPU ALU. It drives the ALU operand and opcode inputs from a fixed vector ROM, captures the ALU result and zero flag, and compares both against a built-in golden model. It sits beside the ALU in the CPU top level, muxed onto the ALU inputs while `busy` is high. Results are reported as pass/fail, an error count and the first failing vector index.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before sampling; legal range 1–7.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `alu_a`  out  32  operand A to the ALU.
- `alu_b`  out  32  operand B to the ALU.
- `alu_op`  out  3  ALU opcode.
- `alu_c`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `busy`  out  1  high from the first DRIVE through the last CHECK.
- `done`  out  1  high while in DONE.
- `pass`  out  1  valid while `done`; 1 iff `err_count` is 0.
- `err_count`  out  4  number of failing vectors, saturating at 15.
- `fail_idx`  out  4  index of the first failing vector; 4'hF if none.

## Operation
- Opcode encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT (signed).
- Opcode 101 never appears in the ROM.
- ADD and SUB wrap modulo 2^32.
- SLT returns 32'd1 or 32'd0.
- Expected zero flag is (expected C == 0).
- The ROM holds 11 vectors, indexed 0–10:
  - 0–6: A=123, B=456 with op 0, 1, 2, 3, 4, 6, 7.
  - 7: A=123, B=123, op 6.
  - 8: A=123, B=123, op 7.
  - 9: A=32'hFFFFFFFF, B=1, op 2.
  - 10: A=32'h80000000, B=1, op 7.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE/DONE + `start`: go to DRIVE, index=0; clear `err_count`, `fail_idx` and `pass`.
  - DRIVE: register ROM[index] onto the `alu_*` outputs, then go to SETTLE.
  - SETTLE: count `SETTLE_CYCLES` cycles, then go to CHECK.
  - CHECK: compare `alu_c` and `alu_zero` against the golden values. A mismatch in either one is a failure.
    - On failure: `err_count` increments (saturating), and `fail_idx` is loaded if it is still 4'hF.
    - If index = 10: go to DONE. Otherwise increment index and go to DRIVE.
  - DONE: hold all results until the next `start`.
- `start` while `busy` is ignored.
- `start` held high across DONE restarts immediately.
- `alu_*` outputs hold their last value in DONE. They are 0 in IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `alu_a`, `alu_b`, `alu_op` = 0.
  - `busy` = 0, `done` = 0, `pass` = 0.
  - `err_count` = 0, `fail_idx` = 4'hF.
- Each vector occupies SETTLE_CYCLES+2 cycles.
- With `SETTLE_CYCLES`=1 and `start` sampled at edge 0:
  - Vector i is presented at edge 3i and checked at edge 3i+2.
  - `done` rises at edge 33.
- The ALU is combinational, so the captured result corresponds to the inputs registered at DRIVE.
- `rst` mid-run aborts immediately to the reset values. No partial results are retained.

## Configuration
- Macro: `ALU_BIST_STOP_ON_FAIL_EN`.
- Defined: the first CHECK failure goes directly to DONE.
  - `err_count` = 1 at that point.
  - `alu_*` keep the failing vector for debug.
- Undefined: all 11 vectors always run, and errors accumulate.

## Structure
- Shared package `alu_bist_pkg` holds:
  - the opcode localparams (`ALU_AND` … `ALU_SLT`);
  - the FSM state enum;
  - the vector count (11);
  - the vector ROM as a constant function `bist_vec(idx)` returning {A, B, op}.
- Sub-module `alu_golden`: a combinational reference model. Inputs a, b, op; outputs exp_c and exp_zero. It is instantiated once and fed from the registered `alu_*` outputs.

## Test plan
- Correct ALU, `start` pulse:
  - Vectors 0–6 produce C = 72, 507, 579, 435, 32'hFFFFFE04, 32'hFFFFFEB3, 1.
  - At edge 33: `done`=1, `pass`=1, `err_count`=0, `fail_idx`=4'hF.
- Correct ALU, edge vectors:
  - Vector 7 gives C=0 with zero=1.
  - Vector 8 gives C=0.
  - Vector 9 gives C=0 (wrap).
  - Vector 10 gives C=1 (signed SLT).
- ALU model with OR forced to AND (macro undefined): `pass`=0, `err_count`=1, `fail_idx`=1, `done` at edge 33.
- Zero flag stuck at 0 (macro undefined):
  - Vectors 7, 8 and 9 fail.
  - Result: `err_count`=3, `fail_idx`=7.
- Macro defined, ADD fault:
  - `done` at edge 9 (after vector 2 is checked at edge 8).
  - `fail_idx`=2, `err_count`=1, `alu_op`=010 held.
- `rst` asserted at edge 10, then `start` pulsed again:
  - During reset, all outputs are at reset values asynchronously.
  - The new run completes normally 33 edges after `start`.
- `start` pulsed during `busy`: no effect; done timing is unchanged.
